// File: rtl/bcd_game_timer_pkg.sv
// Shared game-state encodings, default start time and BCD helpers for the game timer.
package bcd_game_timer_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  localparam int unsigned DEF_START_TENS = 6;
  localparam int unsigned DEF_START_ONES = 0;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Saturating add of a binary amount to a two-digit BCD value.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input int unsigned amt);
    int unsigned sum;
    sum = 32'(v[7:4]) * 32'd10 + 32'(v[3:0]) + amt;
    if (sum > 32'd99) begin
      sum = 32'd99;
    end
    return {4'(sum / 32'd10), 4'(sum % 32'd10)};
  endfunction

endpackage

// File: rtl/bcd_game_timer_sec_tick_gen.sv
// One-second prescaler: counts while run is high, clears on clr, ticks in the wrap cycle.
module sec_tick_gen #(
  parameter int unsigned PRESCALE = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_game_timer.sv
// Two-digit BCD countdown timer driven by the game state.
// Optional bonus-time adder enabled with macro GAME_TIME_BONUS_EN.
module bcd_game_timer
  import bcd_game_timer_pkg::*;
#(
  parameter int unsigned PRESCALE   = 100000000,
  parameter int unsigned START_TENS = DEF_START_TENS,
  parameter int unsigned START_ONES = DEF_START_ONES,
  parameter int unsigned BONUS_SEC  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       bonus,
  output logic [3:0] n1,
  output logic [3:0] n0,
  output logic       timeout
);

  localparam logic [7:0] START_VAL = {4'(START_TENS), 4'(START_ONES)};

  game_state_e st_s;
  logic        tick_s;
  logic        run_s;
  logic        clr_s;
  logic [3:0]  n1_q, n0_q;
  logic [3:0]  n1_d, n0_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  val_s;
  logic [7:0]  val_d;

  assign st_s  = game_state_e'(state);
  assign run_s = (st_s == PLAY);
  assign clr_s = (st_s == HOLD) || (st_s == OVER);
  assign val_s = {n1_q, n0_q};

  sec_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .run (run_s),
    .clr (clr_s),
    .tick(tick_s)
  );

`ifndef GAME_TIME_BONUS_EN
  localparam logic [6:0] unused_bonus_p = 7'(BONUS_SEC);
  logic unused_bonus_s;
  assign unused_bonus_s = bonus ^ unused_bonus_p[0];
`endif

  always_comb begin
    val_d     = val_s;
    timeout_d = 1'b0;
    case (st_s)
      HOLD: begin
        val_d = START_VAL;
      end
      PLAY: begin
        if (tick_s && (val_s != 8'h00)) begin
          val_d = bcd_dec(val_s);
        end else begin
          val_d = val_s;
        end
`ifdef GAME_TIME_BONUS_EN
        // Bonus applies after the decrement, gated on the pre-tick value.
        if (bonus && (val_s != 8'h00)) begin
          val_d = bcd_add_sat(val_d, BONUS_SEC);
        end else begin
          val_d = val_d;
        end
`endif
        timeout_d = tick_s && (val_s == 8'h01) && (val_d == 8'h00);
      end
      PAUSE: begin
        val_d = val_s;
      end
      OVER: begin
        val_d = val_s;
      end
      default: begin
        val_d = val_s;
      end
    endcase
    n1_d = val_d[7:4];
    n0_d = val_d[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n1_q      <= START_VAL[7:4];
      n0_q      <= START_VAL[3:0];
      timeout_q <= 1'b0;
    end else begin
      n1_q      <= n1_d;
      n0_q      <= n0_d;
      timeout_q <= timeout_d;
    end
  end

  assign n1      = n1_q;
  assign n0      = n0_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bcd_game_timer.sv
// Self-checking bench for bcd_game_timer (PRESCALE=4): vector table, corner sequences,
// and randomized stimulus against an integer-seconds reference model.
module tb_bcd_game_timer;
  import bcd_game_timer_pkg::*;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state = 2'd0;
  logic       bonus = 1'b0;
  logic [3:0] n1, n0;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  int   m_val = 60;
  int   m_cnt = 0;
  logic m_to  = 1'b0;

  bcd_game_timer #(
    .PRESCALE(P)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .bonus  (bonus),
    .n1     (n1),
    .n0     (n0),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       b;
    int         n;
    int         exp_val;
    logic       exp_to;
  } vec_t;

  vec_t tbl[12];

  function automatic int dut_val();
    return int'(n1) * 10 + int'(n0);
  endfunction

  // Reference: remaining time as an integer number of seconds.
  task automatic model_edge(input logic [1:0] st, input logic b);
    bit tick;
    int nv;
    m_to = 1'b0;
    if (st == HOLD) begin
      m_val = 60;
      m_cnt = 0;
    end else if (st == PLAY) begin
      tick  = (m_cnt == P - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      nv    = (tick && m_val > 0) ? m_val - 1 : m_val;
`ifdef GAME_TIME_BONUS_EN
      if (b && m_val > 0) nv = (nv + 5 > 99) ? 99 : nv + 5;
`endif
      m_to  = tick && (m_val == 1) && (nv == 0);
      m_val = nv;
    end else if (st == OVER) begin
      m_cnt = 0;
    end
  endtask

  task automatic cyc(input logic [1:0] st, input logic b);
    state = st;
    bonus = b;
    @(posedge clk);
    model_edge(st, b);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_val"}, dut_val(), m_val);
    chk({nm, "_timeout"}, int'(timeout), int'(m_to));
    chk({nm, "_bcd_legal"}, int'(n1 <= 4'd9 && n0 <= 4'd9), 1);
  endtask

  initial begin
    int  prev;
    bit  seen;
    logic [1:0] rs;
    int  r;

    tbl[0]  = '{PLAY,  1'b0, 3,  60, 1'b0};
    tbl[1]  = '{PLAY,  1'b0, 1,  59, 1'b0};
    tbl[2]  = '{PLAY,  1'b0, 4,  58, 1'b0};
    tbl[3]  = '{PLAY,  1'b0, 2,  58, 1'b0};
    tbl[4]  = '{PAUSE, 1'b0, 10, 58, 1'b0};
    tbl[5]  = '{PLAY,  1'b0, 1,  58, 1'b0};
    tbl[6]  = '{PLAY,  1'b0, 1,  57, 1'b0};
    tbl[7]  = '{OVER,  1'b0, 3,  57, 1'b0};
    tbl[8]  = '{PLAY,  1'b0, 3,  57, 1'b0};
    tbl[9]  = '{PLAY,  1'b0, 1,  56, 1'b0};
    tbl[10] = '{HOLD,  1'b0, 1,  60, 1'b0};
    tbl[11] = '{PLAY,  1'b0, 4,  59, 1'b0};

    rst   = 1'b1;
    state = HOLD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_val", dut_val(), 60);
    chk("reset_timeout", int'(timeout), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].st, tbl[i].b);
      chk($sformatf("table%0d_val", i), dut_val(), tbl[i].exp_val);
      chk($sformatf("table%0d_timeout", i), int'(timeout), int'(tbl[i].exp_to));
    end

    // Countdown to expiry; bonus pulses at 30 exercise the configured behaviour.
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      prev = m_val;
      cyc(PLAY, (m_val == 30) ? 1'b1 : 1'b0);
      chk_model("countdown");
      if (prev == 10 && m_val == 9) chk("ten_to_nine", dut_val(), 9);
      if (m_to) begin
        chk("expiry_pulse", int'(timeout), 1);
        chk("expiry_val", dut_val(), 0);
        seen = 1'b1;
      end
    end
    chk("expiry_reached", int'(seen), 1);
    cyc(PLAY, 1'b0);
    chk("pulse_one_cycle", int'(timeout), 0);
    for (int i = 0; i < 12; i++) begin
      cyc(PLAY, i[0]);
      chk("stay_zero_val", dut_val(), 0);
      chk("stay_zero_timeout", int'(timeout), 0);
    end

    cyc(HOLD, 1'b0);
    for (int i = 0; i < 200 && m_val != 37; i++) cyc(PLAY, 1'b0);
    chk("reach_37", dut_val(), 37);
    cyc(HOLD, 1'b0);
    chk("hold_reload", dut_val(), 60);
    for (int i = 0; i < 200 && m_val != 42; i++) cyc(PLAY, 1'b0);
    chk("reach_42", dut_val(), 42);
    cyc(PLAY, 1'b0);
    cyc(PLAY, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_val", dut_val(), 60);
    chk("async_reset_timeout", int'(timeout), 0);
    m_val = 60;
    m_cnt = 0;
    m_to  = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(PLAY, 1'b0);
      chk_model("after_reset");
    end
    chk("after_reset_tick", dut_val(), 59);

`ifdef GAME_TIME_BONUS_EN
    cyc(PAUSE, 1'b1);
    chk("bonus_in_pause", dut_val(), 59);
    for (int i = 0; i < 10; i++) begin
      cyc(PLAY, 1'b1);
      chk_model("bonus_saturate");
    end
    chk("bonus_sat_99", dut_val(), 99);
`endif

    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      rs = (r < 75) ? PLAY : (r < 87) ? PAUSE : (r < 96) ? OVER : HOLD;
      cyc(rs, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      chk_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_game_timer.md
BCD_GAME_TIMER -- requirements
Module: bcd_game_timer

Interface
REQ-001 Parameter PRESCALE, default 100000000, is the number of clk cycles per one-second tick; it SHALL be at least 2.
REQ-002 Parameter START_TENS, default 6, is the tens digit loaded at reset and in HOLD; it SHALL be in the range 0-9.
REQ-003 Parameter START_ONES, default 0, is the ones digit loaded at reset and in HOLD; it SHALL be in the range 0-9.
REQ-004 Parameter BONUS_SEC, default 5, is the two-digit BCD bonus added per bonus pulse; it SHALL be in the range 1-99.
REQ-005 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-007 state  input  2  is the game state, encoded with the shared HOLD/PLAY/PAUSE/OVER constants.
REQ-008 bonus  input  1  is a one-cycle request to add bonus time; the port SHALL exist in every build.
REQ-009 n1  output  4  is the remaining-time tens digit in BCD; it SHALL be registered.
REQ-010 n0  output  4  is the remaining-time ones digit in BCD; it SHALL be registered.
REQ-011 timeout  output  1  is a registered one-cycle pulse marking expiry.

Function
REQ-012 The timer value {n1,n0} SHALL always be a legal BCD value in the range 00-99.
REQ-013 HOLD: {n1,n0} SHALL load {START_TENS,START_ONES} on the next edge, the prescaler SHALL clear to 0, and timeout SHALL be 0.
REQ-014 PLAY: the prescaler SHALL increment by 1 each cycle and wrap from PRESCALE-1 to 0; a tick SHALL be generated in the wrap cycle.
REQ-015 On a tick with the value greater than 00: if n0 is 0, n0 SHALL become 9 and n1 SHALL become n1-1; otherwise n0 SHALL become n0-1.
REQ-016 When a decrement takes the value from 01 to 00, timeout SHALL be 1 in the same cycle that 00 first appears on n1/n0, and 0 on the following cycle.
REQ-017 At 00 the value SHALL stay 00 and no further timeout pulse SHALL occur until the timer is reloaded by HOLD or reset.
REQ-018 PAUSE: the value and the prescaler count SHALL both hold; on return to PLAY, counting SHALL resume from the held prescaler count.
REQ-019 OVER: the value SHALL hold and the prescaler SHALL clear to 0.
REQ-020 The latency from a tick to the updated n1/n0 SHALL be exactly one edge.
REQ-021 A state change SHALL take effect on the first edge that samples the new state, with no extra pipeline stage.

Reset
REQ-022 While rst=1: n1=START_TENS, n0=START_ONES, prescaler=0, timeout=0.
REQ-023 Asserting rst mid-count SHALL force these values immediately, without waiting for a clk edge.
REQ-024 After rst deasserts, the block SHALL resume operating on the first clk edge, following the state input.

Configuration
REQ-025 With macro GAME_TIME_BONUS_EN defined: a bonus pulse in PLAY with a nonzero value SHALL add BONUS_SEC in BCD, saturating at 99.
REQ-026 If a tick and a bonus occur in the same cycle, the decrement SHALL be applied first and then the bonus added; a bonus on a value of 01 together with a tick SHALL suppress the timeout pulse.
REQ-027 With GAME_TIME_BONUS_EN defined, bonus SHALL be ignored in HOLD, PAUSE and OVER, and when the value is 00.
REQ-028 Without GAME_TIME_BONUS_EN, the bonus input SHALL be ignored and no adder logic SHALL be synthesized.

Structure
REQ-029 The state encodings (HOLD, PLAY, PAUSE, OVER) and the default start time SHALL live in the shared global definitions package.
REQ-030 The prescaler SHALL be a sub-module, sec_tick_gen, with inputs clk, rst, run and clr and output tick.
REQ-031 Downstream consumers of n1/n0 (display and score stages) SHALL rely only on the registered outputs.

Verification (PRESCALE=4 unless stated)
REQ-032 Release rst, then hold PLAY from a start of 60 -> n1n0 shows 59 after 4 cycles and 58 after 8 cycles.
REQ-033 Tick at value 10 -> 09; tick at value 01 -> 00 with timeout=1 for exactly one cycle; further ticks -> value stays 00 and timeout stays 0.
REQ-034 PLAY until the prescaler reaches 2, then PAUSE for 10 cycles, then PLAY -> the next tick occurs 2 cycles after resuming and the value is unchanged during PAUSE.
REQ-035 HOLD at value 37 -> 60 on the next edge; assert rst asynchronously at value 42 -> 60 without a clk edge.
REQ-036 With GAME_TIME_BONUS_EN: bonus at 97 -> 99; tick plus bonus at 03 -> 07; bonus at 00 -> stays 00; bonus in PAUSE -> no change.
REQ-037 Without GAME_TIME_BONUS_EN: bonus pulses at 30 in PLAY -> the value follows ticks only.
